// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants, hex segment table and width helper for the seven-segment scanner
package seven_seg_pkg;

    // Segment bit positions inside ss_out ({dp,g,f,e,d,c,b,a}).
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low gfedcba pattern for one hex digit; dp is not part of it.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Ceiling log2, never below 1 so a one-value counter still has a bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - combinational hex digit to active-low gfedcba segments
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,  // hex value to show
    output logic [6:0] seg     // active-low gfedcba
);

    assign seg = hex_to_seg(digit);

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - N-digit multiplexed seven-segment driver with snapshot, lz suppression, dead time and PWM
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GHOST_CYCLES = 500
) (
    input  logic                    clock,        // rising-edge system clock
    input  logic                    reset,        // synchronous, active-high
    input  logic [4*NUM_DIGITS-1:0] number,       // packed hex digits, digit 0 rightmost
    input  logic [NUM_DIGITS-1:0]   dp,           // decimal point request, 1 = lit
    input  logic [NUM_DIGITS-1:0]   blank,        // forced blank, 1 = off
    input  logic                    lz_en,        // leading-zero suppression enable
    input  logic [3:0]              brightness,   // PWM level, 0 = 1/16 .. 15 = 16/16
    output logic [7:0]              ss_out,       // active-low {dp,g,f,e,d,c,b,a}
    output logic [NUM_DIGITS-1:0]   ss_digit,     // active-low digit enables
    output logic                    frame_start   // pulse after each snapshot load
);

    localparam int PRESC_W = clog2_min1(SCAN_DIV);
    localparam int IDX_W   = clog2_min1(NUM_DIGITS);

    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              pwm;
    logic [4*NUM_DIGITS-1:0] shadow_num;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   lz_mask;

    logic                    strobe;
    logic                    slot_end;
    logic                    drive;
    logic [NUM_DIGITS-1:0]   lz_next;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   sel;
    logic [3:0]              cur_num;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              cur_seg;
    logic [7:0]              drive_pattern;

    assign strobe   = (presc == '0) && (idx == '0);
    assign slot_end = (presc == PRESC_W'(SCAN_DIV - 1));

    // Suppression walks down from the top digit and stops at the first
    // nonzero one; digit 0 is outside the loop so "0" always shows.
    always_comb begin
        lz_next = '0;
        lz_run  = lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (number[4*i +: 4] == 4'h0)) begin
                lz_next[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end

    // Select the shadow digit for the current slot.
    always_comb begin
        sel       = '0;
        cur_num   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel[i]    = 1'b1;
                cur_num   = shadow_num[4*i +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = shadow_blank[i] | lz_mask[i];
            end
        end
    end

    seven_seg_decoder u_decoder (
        .digit (cur_num),
        .seg   (cur_seg)
    );

    // Dead time at the start of each slot keeps the previous digit's
    // segments from bleeding into the next digit while lines settle.
    assign drive = (presc >= PRESC_W'(GHOST_CYCLES)) && (pwm <= brightness) && !cur_blank;

    always_comb begin
        drive_pattern         = {1'b1, cur_seg};
        drive_pattern[SEG_DP] = ~cur_dp;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc        <= '0;
            idx          <= '0;
            pwm          <= '0;
            shadow_num   <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            lz_mask      <= '0;
            ss_out       <= SEG_OFF;
            ss_digit     <= '1;
            frame_start  <= 1'b0;
        end else begin
            pwm <= pwm + 4'd1;
            if (slot_end) begin
                presc <= '0;
                idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            frame_start <= strobe;
            if (strobe) begin
                shadow_num   <= number;
                shadow_dp    <= dp;
                shadow_blank <= blank;
                lz_mask      <= lz_next;
            end

            if (drive) begin
                ss_digit <= ~sel;
                ss_out   <= drive_pattern;
            end else begin
                ss_digit <= '1;
                ss_out   <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - scoreboard bench for seven_seg_scanner (4 digits, 8-cycle slots, 2-cycle dead time)
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int SDIV  = 8;
    localparam int GHOST = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [15:0]   number;
    logic [3:0]    dp;
    logic [3:0]    blank;
    logic          lz_en;
    logic [3:0]    brightness;
    logic [7:0]    ss_out;
    logic [3:0]    ss_digit;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    // Full active-low patterns with dp off, straight from the display datasheet order.
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Expected {frame_start, ss_digit, ss_out} per clock.
    logic [12:0] exp_q [$];
    logic [12:0] exp_front;

    // Reference state.
    int         m_presc;
    int         m_idx;
    int         m_pwm;
    logic [3:0] m_num [4];
    logic       m_dp [4];
    logic       m_blank [4];
    logic       m_lz [4];
    int         m_top;
    logic       m_on;
    logic [7:0] m_out;

    seven_seg_scanner #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SDIV),
        .GHOST_CYCLES (GHOST)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .number      (number),
        .dp          (dp),
        .blank       (blank),
        .lz_en       (lz_en),
        .brightness  (brightness),
        .ss_out      (ss_out),
        .ss_digit    (ss_digit),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference: what the registered outputs become at this edge.
    always @(posedge clock) begin
        if (reset) begin
            exp_q.push_back({1'b0, 4'hF, 8'hFF});
            m_presc = 0;
            m_idx   = 0;
            m_pwm   = 0;
            for (int i = 0; i < 4; i++) begin
                m_num[i] = 4'h0; m_dp[i] = 1'b0; m_blank[i] = 1'b0; m_lz[i] = 1'b0;
            end
        end else begin
            m_on = (m_presc >= GHOST) && (m_pwm <= int'(brightness))
                   && !m_blank[m_idx] && !m_lz[m_idx];
            m_out = seg_tab[m_num[m_idx]] & (m_dp[m_idx] ? 8'h7F : 8'hFF);
            exp_q.push_back({(m_presc == 0 && m_idx == 0),
                             m_on ? ~(4'b0001 << m_idx) : 4'hF,
                             m_on ? m_out : 8'hFF});
            if (m_presc == 0 && m_idx == 0) begin
                m_top = 0;
                for (int i = 0; i < 4; i++) begin
                    m_num[i]   = number[4*i +: 4];
                    m_dp[i]    = dp[i];
                    m_blank[i] = blank[i];
                    if (number[4*i +: 4] != 4'h0) m_top = i;
                end
                for (int i = 0; i < 4; i++) m_lz[i] = lz_en && (i > m_top);
            end
            m_pwm   = (m_pwm + 1) % 16;
            m_presc = m_presc + 1;
            if (m_presc == SDIV) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % ND;
            end
        end
    end

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_front = exp_q.pop_front();
            check("scan", {19'd0, frame_start, ss_digit, ss_out}, {19'd0, exp_front});
        end
    end

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_start && n < 80);
        check("frame_seen", {31'd0, frame_start}, 32'd1);
    endtask

    // Wait for a frame, then sample mid on-window of each slot.
    task automatic check_slots(input string tag, input logic [31:0] segs, input logic [15:0] digs);
        wait_frame();
        for (int d = 0; d < 4; d++) begin
            repeat (d == 0 ? 4 : 8) @(negedge clock);
            check({tag, "_dig"}, {28'd0, ss_digit}, {28'd0, digs[4*d +: 4]});
            check({tag, "_seg"}, {24'd0, ss_out}, {24'd0, segs[8*d +: 8]});
        end
    endtask

    initial begin
        reset      = 1'b1;
        number     = 16'hA842;
        dp         = 4'b0000;
        blank      = 4'b0000;
        lz_en      = 1'b0;
        brightness = 4'd15;
        repeat (3) @(negedge clock);
        check("rst_seg", {24'd0, ss_out}, 32'hFF);
        check("rst_dig", {28'd0, ss_digit}, 32'hF);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        reset = 1'b0;

        @(negedge clock);
        check("first_fs", {31'd0, frame_start}, 32'd1);
        check_slots("a842", 32'h888099A4, 16'h7BDE);

        wait_frame();
        repeat (19) @(negedge clock);
        number = 16'h1111;
        check_slots("ones", 32'hF9F9F9F9, 16'h7BDE);

        lz_en  = 1'b1;
        number = 16'h0040;
        check_slots("lz40", 32'hFFFF99C0, 16'hFFDE);
        number = 16'h0000;
        check_slots("lz00", 32'hFFFFFFC0, 16'hFFFE);

        lz_en  = 1'b0;
        number = 16'hA842;
        dp     = 4'b0010;
        blank  = 4'b1000;
        check_slots("dpbl", 32'hFF8019A4, 16'hFBDE);

        dp         = 4'b0000;
        blank      = 4'b0000;
        brightness = 4'd0;
        wait_frame();
        repeat (70) @(negedge clock);

        for (int k = 0; k < 4; k++) begin
            number     = 16'($urandom);
            dp         = 4'($urandom_range(0, 15));
            blank      = 4'($urandom_range(0, 15));
            lz_en      = 1'($urandom_range(0, 1));
            brightness = 4'($urandom_range(0, 15));
            wait_frame();
            repeat (36) @(negedge clock);
        end

        number     = 16'hA842;
        dp         = 4'b0000;
        blank      = 4'b0000;
        lz_en      = 1'b0;
        brightness = 4'd15;
        wait_frame();
        wait_frame();
        repeat (5) @(negedge clock);
        check("lit_before_rst", {28'd0, ss_digit}, 32'hE);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_seg", {24'd0, ss_out}, 32'hFF);
        check("midrst_dig", {28'd0, ss_digit}, 32'hF);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_fs_again", {31'd0, frame_start}, 32'd1);
        check_slots("after_rst", 32'h888099A4, 16'h7BDE);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised N-digit multiplexed seven-segment driver, successor to the fixed 4-digit show_number display path.
- Scans NUM_DIGITS hex digits onto common active-low segment/digit lines.
- Adds frame-coherent input snapshot, per-digit decimal point and blank, leading-zero suppression, anti-ghosting dead time and PWM brightness.
- Sits between the board's number/status logic and the physical display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1).
SCAN_DIV, 50000, clock cycles per digit slot (>=2).
GHOST_CYCLES, 500, dead-time cycles at the start of each slot, all digits off (< SCAN_DIV).

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
number  input  4*NUM_DIGITS  packed hex digits; digit i = number[4i+3:4i]; digit 0 is least significant (rightmost).
dp  input  NUM_DIGITS  per-digit decimal point request, 1 = lit.
blank  input  NUM_DIGITS  per-digit forced blank, 1 = off.
lz_en  input  1  leading-zero suppression enable.
brightness  input  4  PWM level; 0 = 1/16 duty, 15 = 16/16 duty.
ss_out  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
ss_digit  output  NUM_DIGITS  digit enables, active-low; bit i drives digit i.
frame_start  output  1  one-cycle pulse when a new snapshot is loaded.

Behaviour:
- Clock/reset: single clock `clock`; `reset` is synchronous and active-high.
- Reset values: ss_out=8'hFF, ss_digit=all ones, frame_start=0. Prescaler, digit index, pwm counter, shadow number/dp/blank and suppression mask all 0.
- Prescaler `presc` counts 0..SCAN_DIV-1 and wraps to 0. At wrap, index `idx` advances; NUM_DIGITS-1 wraps to 0.
- `pwm` is a free-running 4-bit counter; it wraps 15->0.
- Snapshot load strobe = (presc==0 && idx==0), including the first cycle after reset release. On the strobe:
  - latch number, dp, blank into shadow registers;
  - compute the leading-zero mask from the new values.
- Inputs that change mid-frame have no visible effect until the next strobe.
- Leading-zero mask, when lz_en=1:
  - starting at digit NUM_DIGITS-1 and moving downward, suppress each digit whose value is 0, stopping at the first nonzero digit;
  - digit 0 is never suppressed (all-zero input shows "0").
  - When lz_en=0, the mask is all zeros. lz_en is sampled at the strobe.
- Effective blank = shadow_blank[i] | lz_mask[i].
- Drive condition for the current slot: presc>=GHOST_CYCLES && pwm<=brightness && !eff_blank[idx].
- Outputs are registered, with 1-cycle latency from presc/idx/pwm state:
  - drive true: ss_digit = all ones except bit idx = 0; ss_out = {~shadow_dp[idx], seg(shadow_num[idx])}.
  - drive false: ss_digit = all ones, ss_out = 8'hFF.
- Never more than one ss_digit bit low. During the dead time, all bits are high.
- frame_start is registered; it is high on the cycle after the strobe.
- Hex decode uses active-low gfedcba for 0-F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E. The dp bit is handled separately.
- Reset asserted mid-slot: outputs return to reset values on the next edge, and scanning restarts at digit 0 with a fresh snapshot.
- NUM_DIGITS=1: idx stays 0, and a strobe occurs every slot.

Decomposition:
- Package seven_seg_pkg:
  - hex-to-segment function/constant table;
  - SEG_OFF=8'hFF;
  - segment bit-position constants;
  - clog2 helper for the idx/presc widths.
- Sub-module seven_seg_decoder: combinational 4-bit -> 7-bit active-low, no dp. Instantiated once on the muxed shadow digit.

Test Plan:
All cases use NUM_DIGITS=4, SCAN_DIV=8, GHOST_CYCLES=2, brightness=15 unless stated otherwise.
- Reset held 3 cycles -> ss_out=FF, ss_digit=1111, frame_start=0. After release, frame_start pulses once on cycle 1, then every 32 cycles.
- number=16'hA842, dp=0, blank=0 -> each slot shows 2 cycles off (1111/FF), then 6 cycles of the digit pattern:
  - 1110 with A4, then 1101 with 99, then 1011 with 80, then 0111 with 88;
  - the sequence repeats.
- Change number to 16'h1111 mid-frame (during digit 2) -> digit 2/3 patterns stay 80/88 until the next frame_start, then show F9.
- lz_en=1, number=16'h0040 -> digits 3 and 2 never enabled, digit 1 shows 99, digit 0 shows C0. With number=0, only digit 0 is enabled, showing C0.
- dp=4'b0010, blank=4'b1000 -> digit 1 ss_out=19 (99 with bit7 cleared); digit 3 line stays high for the whole frame.
- brightness=0 -> in each on-window, a digit is enabled only on cycles where pwm==0 (1 of every 16). Reset asserted mid-slot -> FF/1111 next cycle.
